// File: rtl/dct_top.sv
// Streaming 8-point DCT-II: one block of eight enabled samples in, eight registered
// coefficients out, with X[0] leaving on the same edge as the block's last sample.
module dct_top #(
  parameter int N    = 8,
  parameter int FRAC = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic signed [15:0] data_in,
  output logic signed [15:0] dct_out
);

  localparam int cnt_w = $clog2(N);
  localparam int acc_w = 35;
  localparam logic [cnt_w-1:0]        last_cnt   = cnt_w'(N - 1);
  localparam logic [cnt_w:0]          idle_idx   = (cnt_w + 1)'(N);
  localparam logic signed [acc_w-1:0] round_half = acc_w'(1) <<< (FRAC - 1);

  logic signed [15:0] buffer [N-1];
  logic signed [15:0] bank   [N];
  logic signed [15:0] x_res  [N];
  logic [cnt_w-1:0]   in_cnt;
  logic [cnt_w:0]     out_idx;

  // 2^13 * cos(j*pi/16) for the first quadrant; the other quadrants follow by symmetry.
  function automatic logic signed [15:0] cos_q(input int j);
    case (j)
      0:       return 16'sd8192;
      1:       return 16'sd8035;
      2:       return 16'sd7568;
      3:       return 16'sd6811;
      4:       return 16'sd5793;
      5:       return 16'sd4551;
      6:       return 16'sd3135;
      7:       return 16'sd1598;
      default: return 16'sd0;
    endcase
  endfunction

  // Coefficient table for FRAC = 14; row 0 carries the 1/sqrt(2) normalisation.
  function automatic logic signed [15:0] coef(input int k, input int n);
    int m;
    m = ((2 * n + 1) * k) % 32;
    if (k == 0)       return 16'sd5793;
    else if (m <= 8)  return cos_q(m);
    else if (m <= 16) return -cos_q(16 - m);
    else if (m <= 24) return -cos_q(m - 16);
    else              return cos_q(32 - m);
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [acc_w-1:0] v);
    if (v > acc_w'(32767))       return 16'sd32767;
    else if (v < acc_w'(-32768)) return -16'sd32768;
    else                         return v[15:0];
  endfunction

  // The eighth sample is taken straight from data_in so X[0] needs no extra cycle.
  always_comb begin
    logic signed [acc_w-1:0] acc;
    logic signed [31:0]      prod;
    // NOTE: every variable gets a value before any branch or loop, so no latch is inferred.
    acc  = '0;
    prod = '0;
    for (int k = 0; k < N; k++) begin
      acc = '0;
      for (int n = 0; n < N - 1; n++) begin
        prod = buffer[n] * coef(k, n);
        acc  = acc + acc_w'(prod);
      end
      prod     = data_in * coef(k, N - 1);
      acc      = acc + acc_w'(prod) + round_half;
      x_res[k] = sat16(acc >>> FRAC);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: buffer and bank are reset too, since every register must read zero under reset.
      for (int i = 0; i < N - 1; i++) buffer[i] <= '0;
      for (int i = 0; i < N; i++)     bank[i]   <= '0;
      in_cnt  <= '0;
      out_idx <= idle_idx;
      dct_out <= '0;
    end else if (enable) begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      in_cnt <= in_cnt + 1'b1;
      if (in_cnt != last_cnt) begin
        buffer[in_cnt] <= data_in;
      end
      if (in_cnt == last_cnt) begin
        bank    <= x_res;
        dct_out <= x_res[0];
        out_idx <= (cnt_w + 1)'(1);
      end else if (out_idx != idle_idx) begin
        dct_out <= bank[out_idx[cnt_w-1:0]];
        out_idx <= out_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dct_top.sv
// Directed and reference-model bench for the streaming 8-point DCT.
module tb_dct_top;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [15:0] data_in;
  logic signed [15:0] dct_out;

  int n_cmp = 0;
  int n_err = 0;

  int imp_exp [8] = '{5793, 8035, 7568, 6811, 5793, 4551, 3135, 1598};
  int smp [111];

  dct_top #(.N(8), .FRAC(14)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .data_in(data_in),
    .dct_out(dct_out)
  );

  always #5 clk = ~clk;

  // Drive away from the active edge, sample 1 time unit after it.
  task automatic step(input logic en, input int d);
    @(negedge clk);
    enable  = en;
    data_in = 16'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic real ref_x(input int b, input int k);
    real s;
    real pi;
    pi = 3.14159265358979323846;
    s  = 0.0;
    for (int n = 0; n < 8; n++)
      s = s + real'(smp[b * 8 + n]) * $cos(real'((2 * n + 1) * k) * pi / 16.0);
    s = s * ((k == 0) ? 0.5 / $sqrt(2.0) : 0.5);
    if (s > 32767.0)  s = 32767.0;
    if (s < -32768.0) s = -32768.0;
    return s;
  endfunction

  task automatic test_reset();
    rst     = 1'b1;
    enable  = 1'b0;
    data_in = '0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (int'(dct_out) !== 0) begin
      $display("FAIL reset_out: got %0d expected 0", dct_out);
      n_err++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, int'($urandom_range(65535)) - 32768);
      n_cmp++;
      if (int'(dct_out) !== 0) begin
        $display("FAIL reset_partial_%0d: got %0d expected 0", i, dct_out);
        n_err++;
      end
    end
  endtask

  task automatic test_dc();
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1000);
    n_cmp++;
    if (int'(dct_out) !== 2829) begin
      $display("FAIL dc_x0: got %0d expected 2829", dct_out);
      n_err++;
    end
    for (int k = 1; k < 8; k++) begin
      step(1'b1, 0);
      n_cmp++;
      if (int'(dct_out) !== 0) begin
        $display("FAIL dc_x%0d: got %0d expected 0", k, dct_out);
        n_err++;
      end
    end
  endtask

  task automatic test_impulse();
    do_reset();
    step(1'b1, 16384);
    for (int i = 1; i < 8; i++) step(1'b1, 0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step(1'b1, 0);
      n_cmp++;
      if (int'(dct_out) !== imp_exp[k]) begin
        $display("FAIL impulse_x%0d: got %0d expected %0d", k, dct_out, imp_exp[k]);
        n_err++;
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 32767);
    n_cmp++;
    if (int'(dct_out) !== 32767) begin
      $display("FAIL sat_pos_x0: got %0d expected 32767", dct_out);
      n_err++;
    end
    for (int k = 1; k < 8; k++) begin
      step(1'b1, -32768);
      n_cmp++;
      if (int'(dct_out) !== 0) begin
        $display("FAIL sat_pos_x%0d: got %0d expected 0", k, dct_out);
        n_err++;
      end
    end
    step(1'b1, -32768);
    n_cmp++;
    if (int'(dct_out) !== -32768) begin
      $display("FAIL sat_neg_x0: got %0d expected -32768", dct_out);
      n_err++;
    end
  endtask

  // Impulse outputs stream while a DC block enters with a 3-cycle enable gap.
  task automatic test_enable_gap();
    do_reset();
    step(1'b1, 16384);
    for (int i = 1; i < 8; i++) step(1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1000);
      n_cmp++;
      if (int'(dct_out) !== imp_exp[i + 1]) begin
        $display("FAIL gap_pre_%0d: got %0d expected %0d", i, dct_out, imp_exp[i + 1]);
        n_err++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32767);
      n_cmp++;
      if (int'(dct_out) !== 6811) begin
        $display("FAIL gap_frozen_%0d: got %0d expected 6811", i, dct_out);
        n_err++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1000);
      n_cmp++;
      if (int'(dct_out) !== imp_exp[i + 4]) begin
        $display("FAIL gap_post_%0d: got %0d expected %0d", i, dct_out, imp_exp[i + 4]);
        n_err++;
      end
    end
    step(1'b1, 1000);
    n_cmp++;
    if (int'(dct_out) !== 2829) begin
      $display("FAIL gap_dc_x0: got %0d expected 2829", dct_out);
      n_err++;
    end
    for (int k = 1; k < 8; k++) begin
      step(1'b1, 0);
      n_cmp++;
      if (int'(dct_out) !== 0) begin
        $display("FAIL gap_dc_x%0d: got %0d expected 0", k, dct_out);
        n_err++;
      end
    end
  endtask

  task automatic test_reset_mid_block();
    do_reset();
    step(1'b1, 16384);
    for (int i = 1; i < 8; i++) step(1'b1, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 12345);
    n_cmp++;
    if (int'(dct_out) !== 4551) begin
      $display("FAIL mid_pre_reset: got %0d expected 4551", dct_out);
      n_err++;
    end
    @(negedge clk);
    enable = 1'b0;
    rst    = 1'b1;
    #1;
    n_cmp++;
    if (int'(dct_out) !== 0) begin
      $display("FAIL mid_async_clear: got %0d expected 0", dct_out);
      n_err++;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1000);
      n_cmp++;
      if (int'(dct_out) !== 0) begin
        $display("FAIL mid_idle_%0d: got %0d expected 0", i, dct_out);
        n_err++;
      end
    end
    step(1'b1, 1000);
    n_cmp++;
    if (int'(dct_out) !== 2829) begin
      $display("FAIL mid_dc_x0: got %0d expected 2829", dct_out);
      n_err++;
    end
    for (int k = 1; k < 8; k++) begin
      step(1'b1, 0);
      n_cmp++;
      if (int'(dct_out) !== 0) begin
        $display("FAIL mid_dc_x%0d: got %0d expected 0", k, dct_out);
        n_err++;
      end
    end
  endtask

  // 100 random samples, zero padding to 13 full blocks, then 7 flush edges.
  task automatic test_back_to_back();
    int  b;
    int  k;
    real r;
    real diff;
    do_reset();
    for (int i = 0; i < 111; i++)
      smp[i] = (i < 100) ? int'($urandom_range(4095)) - 2048 : 0;
    for (int i = 0; i < 111; i++) begin
      step(1'b1, smp[i]);
      if (i >= 7) begin
        if (i % 8 == 7) begin
          b = i / 8;
          k = 0;
        end else begin
          b = i / 8 - 1;
          k = i % 8 + 1;
        end
        r    = ref_x(b, k);
        diff = real'(dct_out) - r;
        n_cmp++;
        if (diff > 1.0 || diff < -1.0) begin
          $display("FAIL b2b_blk%0d_x%0d: got %0d expected %f", b, k, dct_out, r);
          n_err++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_impulse();
    test_saturation();
    test_enable_gap();
    test_reset_mid_block();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
